regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port among three writeback sources:
//  0 = ALU, 1 = multdiv (long latency), 2 = memory/IO load.
//  Uses round-robin arbitration with a valid/ready handshake per source.
//  Drives ctrl_writeEnable, ctrl_writeReg and data_writeReg into the register file.
//  ctrl_writeReg feeds the 5-to-32 write-select decoder.
// PARAMETERS
//  DATA_W  32  width of writeback data
//  ADDR_W  5   register index width (register file depth = 2**ADDR_W)
// PORTS
//  clock             in   1       rising-edge clock
//  reset             in   1       asynchronous, active-high
//  wb_hold           in   1       1 = freeze arbitration (no grants)
//  req_valid         in   3       per source: write request present
//  req_reg           in   3*ADDR_W  per source destination index; source i uses bits [i*ADDR_W +: ADDR_W]
//  req_data          in   3*DATA_W  per source write data; source i uses bits [i*DATA_W +: DATA_W]
//  req_ready         out  3       per source: request accepted this cycle
//  ctrl_writeEnable  out  1       register file write enable (registered)
//  ctrl_writeReg     out  ADDR_W  register file write index (registered)
//  data_writeReg     out  DATA_W  register file write data (registered)
//  rr_ptr            out  2       current highest-priority source, for debug
// BEHAVIOUR
//  Reset (async, immediate):
//   - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, rr_ptr=0.
//   - req_ready=0 while reset is high.
//   - A write accepted in the cycle reset rises is discarded.
//  Handshake:
//   - A transfer occurs when req_valid[i] && req_ready[i] are high at a clock edge.
//   - Once req_valid[i] is raised, the source holds req_valid[i], req_reg and req_data stable until the transfer.
//  Grant (combinational):
//   - When wb_hold=0, grant the first valid source searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
//   - req_ready is one-hot or zero. It is never asserted for a source with valid=0.
//   - When wb_hold=1, req_ready=0.
//  Pointer:
//   - After a transfer by source g, rr_ptr <= (g+1) mod 3.
//   - With no transfer, rr_ptr holds. rr_ptr never takes the value 3.
//  Output stage:
//   - On a transfer by g: the next cycle drives ctrl_writeReg=req_reg[g], data_writeReg=req_data[g].
//   - ctrl_writeEnable=1 on that cycle, except 0 if req_reg[g]==0 (r0 is never written; the request still completes).
//   - With no transfer, ctrl_writeEnable=0 next cycle; ctrl_writeReg and data_writeReg hold.
//  Latency:
//   - Exactly 1 cycle from the accepting edge to ctrl_writeEnable high.
//   - Throughput is 1 write per cycle.
//  Same-register collisions:
//   - Sources are serialized in round-robin order; the later grant overwrites.
//   - No merging or dropping, except the r0 rule.
//  Fairness:
//   - A continuously valid source is granted within 3 cycles while wb_hold=0.
//  wb_hold:
//   - Raising wb_hold mid-stream does not cancel a write already registered. That write still appears on the next cycle.
// TESTING
//  1. Reset: assert reset mid-cycle with req_valid=3'b111 ->
//     outputs go 0 immediately; req_ready=0; rr_ptr=0 after release.
//  2. Single source: valid[1] with reg 7, data 32'hDEADBEEF ->
//     req_ready=3'b010 same cycle; next cycle WE=1, reg=7, data=DEADBEEF.
//  3. Round robin: valid=3'b111 held for 6 cycles ->
//     grants 0,1,2,0,1,2; WE high on 6 consecutive cycles.
//  4. r0 drop: valid[2] with reg 0, data 5 ->
//     ready[2]=1; next cycle WE=0; rr_ptr becomes 0.
//  5. Hold: wb_hold=1 while valid=3'b011 ->
//     ready=0 and WE=0 after drain; on release, grant follows rr_ptr.
//  6. Collision: sources 0 and 1 both target reg 9 with data 1 and 2, rr_ptr=1 ->
//     write 2, then write 1; final reg9=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among ALU (0),
// multdiv (1) and load (2) writeback sources, with a registered write stage.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_hold,
  input  logic [2:0]            req_valid,
  input  logic [3*ADDR_W-1:0]   req_reg,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            req_ready,
  output logic                  ctrl_writeEnable,
  output logic [ADDR_W-1:0]     ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg,
  output logic [1:0]            rr_ptr
);

  logic [2:0]        grant_p0;
  logic [1:0]        gidx_p0;
  logic [1:0]        cand_p0;
  logic              xfer_p0;
  logic [ADDR_W-1:0] sel_reg_p0;
  logic [DATA_W-1:0] sel_data_p0;

  // Modulo-3 add; base and step are always in 0..2.
  function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    wrap3 = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  // Stage p0: combinational grant. Scan lowest priority first so the
  // highest-priority valid source (at rr_ptr) is the last one written.
  always_comb begin
    grant_p0 = '0;
    gidx_p0  = '0;
    cand_p0  = '0;
    if (!reset && !wb_hold) begin
      for (int k = 2; k >= 0; k--) begin
        cand_p0 = wrap3(rr_ptr, 2'(k));
        if (req_valid[cand_p0]) begin
          grant_p0          = '0;
          grant_p0[cand_p0] = 1'b1;
          gidx_p0           = cand_p0;
        end
      end
    end
  end

  assign req_ready = grant_p0;
  assign xfer_p0   = |grant_p0;

  always_comb begin
    sel_reg_p0  = req_reg[0 +: ADDR_W];
    sel_data_p0 = req_data[0 +: DATA_W];
    case (gidx_p0)
      2'd1: begin
        sel_reg_p0  = req_reg[ADDR_W +: ADDR_W];
        sel_data_p0 = req_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_reg_p0  = req_reg[2*ADDR_W +: ADDR_W];
        sel_data_p0 = req_data[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  // Stage p1: registered write port. A write to r0 still completes the
  // handshake and advances the pointer, but never asserts the enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      rr_ptr           <= 2'd0;
    end else begin
      ctrl_writeEnable <= xfer_p0 && (sel_reg_p0 != '0);
      if (xfer_p0) begin
        ctrl_writeReg <= sel_reg_p0;
        data_writeReg <= sel_data_p0;
        rr_ptr        <= wrap3(gidx_p0, 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a reference grant model pushes expected write
// port values into a queue at drive time; they are popped after each edge.
module tb_regfile_wb_arbiter;

  logic          clock;
  logic          reset;
  logic          wb_hold;
  logic [2:0]    req_valid;
  logic [14:0]   req_reg;
  logic [95:0]   req_data;
  logic [2:0]    req_ready;
  logic          ctrl_writeEnable;
  logic [4:0]    ctrl_writeReg;
  logic [31:0]   data_writeReg;
  logic [1:0]    rr_ptr;

  typedef struct packed {
    logic        we;
    logic [4:0]  rg;
    logic [31:0] dt;
  } wb_t;

  wb_t         sbq[$];
  logic [1:0]  m_ptr;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [31:0] shadow [32];
  int          total;
  int          bad;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock            (clock),
    .reset            (reset),
    .wb_hold          (wb_hold),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .rr_ptr           (rr_ptr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (!reset && ctrl_writeEnable) shadow[ctrl_writeReg] <= data_writeReg;
  end

  function automatic logic [2:0] exp_grant(input logic [2:0] v, input logic h, input logic [1:0] p);
    logic [2:0] r;
    int s;
    r = 3'b000;
    if (!h) begin
      for (int k = 0; k < 3; k++) begin
        s = (int'(p) + k) % 3;
        if (v[s] && r == 3'b000) r[s] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_accept(input logic [2:0] g);
    wb_t e;
    e.we = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (g[s]) begin
        m_reg  = req_reg[s*5 +: 5];
        m_data = req_data[s*32 +: 32];
        e.we   = (m_reg != 5'd0);
        m_ptr  = (s == 2) ? 2'd0 : 2'(s + 1);
      end
    end
    e.rg = m_reg;
    e.dt = m_data;
    sbq.push_back(e);
  endtask

  task automatic model_clear();
    sbq.delete();
    m_ptr  = 2'd0;
    m_reg  = 5'd0;
    m_data = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    req_valid = 3'b000;
    wb_hold   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    wb_t e;
    req_valid = 3'b111;
    req_reg   = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    @(negedge clock); #1;
    total++;
    if (req_ready !== 3'b000 || ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 ||
        data_writeReg !== 32'd0 || rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL reset_hold: ready=%b we=%b reg=%0d data=%h ptr=%0d want all zero",
               req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, rr_ptr);
    end
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if (req_ready !== 3'b001) begin
      bad++;
      $display("FAIL reset_first_grant: got %b want 001", req_ready);
    end
    model_accept(3'b001);
    @(posedge clock); #1;
    e = sbq.pop_front();
    total++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e) begin
      bad++;
      $display("FAIL reset_pre_write: got %b/%0d/%h want %b/%0d/%h",
               ctrl_writeEnable, ctrl_writeReg, data_writeReg, e.we, e.rg, e.dt);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (req_ready !== 3'b000 || ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 ||
        data_writeReg !== 32'd0 || rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL reset_async: ready=%b we=%b reg=%0d data=%h ptr=%0d want all zero",
               req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, rr_ptr);
    end
    @(posedge clock); #1;
    total++;
    if (ctrl_writeEnable !== 1'b0 || data_writeReg !== 32'd0) begin
      bad++;
      $display("FAIL reset_discard: we=%b data=%h want 0/0", ctrl_writeEnable, data_writeReg);
    end
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 3'b000;
    model_clear();
    #1;
    total++;
    if (rr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL reset_ptr: got %0d want 0", rr_ptr);
    end
  endtask

  task automatic test_single();
    logic [2:0] g;
    wb_t e;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      req_valid       = (c == 0) ? 3'b010 : 3'b000;
      req_reg[5 +: 5] = 5'd7;
      req_data[32 +: 32] = 32'hDEADBEEF;
      #1;
      g = exp_grant(req_valid, wb_hold, m_ptr);
      total++;
      if (req_ready !== g) begin
        bad++;
        $display("FAIL single_ready c=%0d: got %b want %b", c, req_ready, g);
      end
      model_accept(g);
      @(posedge clock); #1;
      e = sbq.pop_front();
      total++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e) begin
        bad++;
        $display("FAIL single_write c=%0d: got %b/%0d/%h want %b/%0d/%h", c,
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, e.we, e.rg, e.dt);
      end
    end
    total++;
    if (rr_ptr !== m_ptr) begin
      bad++;
      $display("FAIL single_ptr: got %0d want %0d", rr_ptr, m_ptr);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] g;
    wb_t e;
    do_reset();
    req_reg  = {5'd12, 5'd11, 5'd10};
    req_data = {32'h2000, 32'h1000, 32'h0000};
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      req_valid = (c < 6) ? 3'b111 : 3'b000;
      #1;
      g = exp_grant(req_valid, wb_hold, m_ptr);
      total++;
      if (req_ready !== g) begin
        bad++;
        $display("FAIL rr_ready c=%0d: got %b want %b", c, req_ready, g);
      end
      model_accept(g);
      @(posedge clock); #1;
      e = sbq.pop_front();
      total++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e) begin
        bad++;
        $display("FAIL rr_write c=%0d: got %b/%0d/%h want %b/%0d/%h", c,
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, e.we, e.rg, e.dt);
      end
      total++;
      if (rr_ptr !== m_ptr) begin
        bad++;
        $display("FAIL rr_ptr c=%0d: got %0d want %0d", c, rr_ptr, m_ptr);
      end
      for (int s = 0; s < 3; s++)
        if (g[s]) req_data[s*32 +: 32] = req_data[s*32 +: 32] + 32'd1;
    end
  endtask

  task automatic test_r0_drop();
    logic [2:0] g;
    wb_t e;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      req_valid           = (c == 0) ? 3'b100 : 3'b000;
      req_reg[10 +: 5]    = 5'd0;
      req_data[64 +: 32]  = 32'd5;
      #1;
      g = exp_grant(req_valid, wb_hold, m_ptr);
      total++;
      if (req_ready !== g) begin
        bad++;
        $display("FAIL r0_ready c=%0d: got %b want %b", c, req_ready, g);
      end
      model_accept(g);
      @(posedge clock); #1;
      e = sbq.pop_front();
      total++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e) begin
        bad++;
        $display("FAIL r0_write c=%0d: got %b/%0d/%h want %b/%0d/%h", c,
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, e.we, e.rg, e.dt);
      end
      total++;
      if (rr_ptr !== m_ptr) begin
        bad++;
        $display("FAIL r0_ptr c=%0d: got %0d want %0d", c, rr_ptr, m_ptr);
      end
    end
  endtask

  task automatic test_hold();
    logic [2:0] g;
    wb_t e;
    logic [2:0] vtab [6] = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b001};
    logic       htab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    req_reg  = {5'd6, 5'd5, 5'd4};
    req_data = {32'hC0, 32'hB0, 32'hA0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      wb_hold   = htab[c];
      req_valid = vtab[c];
      #1;
      g = exp_grant(req_valid, wb_hold, m_ptr);
      total++;
      if (req_ready !== g) begin
        bad++;
        $display("FAIL hold_ready c=%0d: got %b want %b", c, req_ready, g);
      end
      model_accept(g);
      @(posedge clock); #1;
      e = sbq.pop_front();
      total++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e) begin
        bad++;
        $display("FAIL hold_write c=%0d: got %b/%0d/%h want %b/%0d/%h", c,
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, e.we, e.rg, e.dt);
      end
      total++;
      if (rr_ptr !== m_ptr) begin
        bad++;
        $display("FAIL hold_ptr c=%0d: got %0d want %0d", c, rr_ptr, m_ptr);
      end
      for (int s = 0; s < 3; s++)
        if (g[s]) req_data[s*32 +: 32] = req_data[s*32 +: 32] + 32'd1;
    end
    wb_hold = 1'b0;
  endtask

  task automatic test_collision();
    logic [2:0] g;
    wb_t e;
    logic [2:0] vtab [3] = '{3'b011, 3'b001, 3'b000};
    @(negedge clock);
    req_valid = 3'b000;
    #1;
    total++;
    if (rr_ptr !== 2'd1) begin
      bad++;
      $display("FAIL coll_start_ptr: got %0d want 1", rr_ptr);
    end
    req_reg  = {5'd0, 5'd9, 5'd9};
    req_data = {32'd0, 32'd2, 32'd1};
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      req_valid = vtab[c];
      #1;
      g = exp_grant(req_valid, wb_hold, m_ptr);
      total++;
      if (req_ready !== g) begin
        bad++;
        $display("FAIL coll_ready c=%0d: got %b want %b", c, req_ready, g);
      end
      model_accept(g);
      @(posedge clock); #1;
      e = sbq.pop_front();
      total++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e) begin
        bad++;
        $display("FAIL coll_write c=%0d: got %b/%0d/%h want %b/%0d/%h", c,
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, e.we, e.rg, e.dt);
      end
    end
    @(negedge clock);
    total++;
    if (shadow[9] !== 32'd1) begin
      bad++;
      $display("FAIL coll_final_r9: got %0d want 1", shadow[9]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] g;
    logic [2:0] prev_g;
    wb_t e;
    int wait_cnt [3];
    prev_g = 3'b000;
    for (int s = 0; s < 3; s++) wait_cnt[s] = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      req_valid = req_valid & ~prev_g;
      for (int s = 0; s < 3; s++) begin
        if (!req_valid[s] && $urandom_range(0, 3) != 0) begin
          req_valid[s]          = 1'b1;
          req_reg[s*5 +: 5]     = 5'($urandom_range(0, 31));
          req_data[s*32 +: 32]  = $urandom;
          wait_cnt[s]           = 0;
        end
      end
      wb_hold = ($urandom_range(0, 4) == 0);
      #1;
      g = exp_grant(req_valid, wb_hold, m_ptr);
      total++;
      if (req_ready !== g) begin
        bad++;
        $display("FAIL b2b_ready c=%0d: got %b want %b", c, req_ready, g);
      end
      for (int s = 0; s < 3; s++) begin
        if (req_valid[s] && !wb_hold) wait_cnt[s]++;
        if (g[s]) begin
          total++;
          if (wait_cnt[s] > 3) begin
            bad++;
            $display("FAIL b2b_fair src=%0d: waited %0d want <=3", s, wait_cnt[s]);
          end
        end
      end
      model_accept(g);
      prev_g = g;
      @(posedge clock); #1;
      e = sbq.pop_front();
      total++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e) begin
        bad++;
        $display("FAIL b2b_write c=%0d: got %b/%0d/%h want %b/%0d/%h", c,
                 ctrl_writeEnable, ctrl_writeReg, data_writeReg, e.we, e.rg, e.dt);
      end
      total++;
      if (rr_ptr !== m_ptr) begin
        bad++;
        $display("FAIL b2b_ptr c=%0d: got %0d want %0d", c, rr_ptr, m_ptr);
      end
    end
    @(negedge clock);
    req_valid = 3'b000;
    wb_hold   = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    wb_hold   = 1'b0;
    req_valid = 3'b000;
    req_reg   = '0;
    req_data  = '0;
    model_clear();
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    test_reset();
    test_single();
    test_round_robin();
    test_r0_drop();
    test_hold();
    test_collision();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
